// File: rtl/mul_tiled_pipe.sv
// Three-stage pipelined unsigned multiplier: tiles A/B into DSP-sized products, then sums them.
// Optional MUL_PP_OUT_EN exposes the raw tile products (pp_flat), aligned with out_p.
module mul_tiled_pipe #(
  parameter int unsigned A_W   = 54,
  parameter int unsigned B_W   = 54,
  parameter int unsigned TA    = 27,
  parameter int unsigned TB    = 18,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned NA   = (A_W + TA - 1) / TA,
  localparam int unsigned NB   = (B_W + TB - 1) / TB,
  localparam int unsigned P_W  = A_W + B_W,
  localparam int unsigned PP_W = TA + TB,
  localparam int unsigned NPP  = NA * NB
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     in_a,
  input  logic [B_W-1:0]     in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_W-1:0]     out_p,
  output logic [TAG_W-1:0]   out_tag
`ifdef MUL_PP_OUT_EN
  ,
  output logic [NPP*PP_W-1:0] pp_flat
`endif
);

  localparam int unsigned AX_W  = NA * TA;
  localparam int unsigned BX_W  = NB * TB;
  localparam int unsigned SUM_W = AX_W + BX_W;

  logic                      stall;
  logic                      v1, v2;
  logic [AX_W-1:0]           a_q;
  logic [BX_W-1:0]           b_q;
  logic [TAG_W-1:0]          tag1, tag2;
  logic [NPP-1:0][PP_W-1:0]  prod_c;
  logic [NPP-1:0][PP_W-1:0]  pp_q;
  logic [SUM_W-1:0]          acc [NPP+1];

  // The whole pipe freezes while the output beat is refused.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  assign acc[0] = '0;

  // Tile products (slice index j*NA+i) and the shifted-sum chain.
  for (genvar k = 0; k < NPP; k++) begin : g_tile
    localparam int unsigned I  = k % NA;
    localparam int unsigned J  = k / NA;
    localparam int unsigned SH = I * TA + J * TB;
    assign prod_c[k] = PP_W'(a_q[I*TA +: TA]) * PP_W'(b_q[J*TB +: TB]);
    assign acc[k+1]  = acc[k] + (SUM_W'(pp_q[k]) << SH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      tag1      <= '0;
      tag2      <= '0;
      pp_q      <= '0;
      out_p     <= '0;
      out_tag   <= '0;
    end else if (!stall) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (in_valid) begin
        a_q  <= AX_W'(in_a);
        b_q  <= BX_W'(in_b);
        tag1 <= in_tag;
      end
      if (v1) begin
        pp_q <= prod_c;
        tag2 <= tag1;
      end
      // out_p only moves on a valid beat so it holds through bubbles.
      if (v2) begin
        out_p   <= acc[NPP][P_W-1:0];
        out_tag <= tag2;
      end
    end
  end

`ifdef MUL_PP_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pp_flat <= '0;
    end else if (!stall && v2) begin
      pp_flat <= pp_q;
    end
  end
`endif

endmodule

// File: tb/tb_mul_tiled_pipe.sv
// Directed bench for mul_tiled_pipe: latency, corner products, backpressure and reset flush.
module tb_mul_tiled_pipe;
  localparam int unsigned A_W   = 54;
  localparam int unsigned B_W   = 54;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned P_W   = 108;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [P_W-1:0]   out_p;
  logic [TAG_W-1:0] out_tag;

  mul_tiled_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [P_W-1:0]   p;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;

  exp_t             exp_q[$];
  logic [P_W-1:0]   drv_exp;
  logic             lat_chk;
  logic             stall_prev = 1'b0;
  logic [P_W-1:0]   prev_p;
  logic [TAG_W-1:0] prev_tag;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: records accepted beats and checks every output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_p", out_p, prev_p);
        check("hold_tag", out_tag, prev_tag);
        check("hold_valid", out_valid, 1);
      end
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 128'(exp_q.size()), 128'(1));
        end else begin
          e = exp_q.pop_front();
          check("out_p", out_p, e.p);
          check("out_tag", out_tag, e.tag);
          if (lat_chk) check("latency", 128'(cyc), 128'(e.due));
        end
      end
      if (in_valid && in_ready) exp_q.push_back('{drv_exp, in_tag, cyc + 3});
      stall_prev = out_valid && !out_ready;
      prev_p     = out_p;
      prev_tag   = out_tag;
    end
  end

  task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                      input logic [TAG_W-1:0] t, input logic [P_W-1:0] e);
    int n = 0;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    drv_exp  = e;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 128'(exp_q.size()), 128'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [11:0]    rdy_pat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    drv_exp   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed corner products.
    send(54'd3, 54'd5, 4'd1, 108'd15);
    drain();
    send(54'h3F_FFFF_FFFF_FFFF, 54'h3F_FFFF_FFFF_FFFF, 4'd2, 108'hFFFFFFFFFFFFF80000000000001);
    send(54'd1 << 27, 54'd1 << 18, 4'd3, 108'd1 << 45);
    send(54'd1 << 53, 54'd1 << 53, 4'd4, 108'd1 << 106);
    drain();

    // Eight back-to-back beats.
    for (int k = 0; k < 8; k++) begin
      a = A_W'({$urandom, $urandom});
      b = B_W'({$urandom, $urandom});
      send(a, b, TAG_W'(k + 5), P_W'(a) * P_W'(b));
    end
    drain();

    // Full pipe held off for four cycles, then an irregular ready pattern.
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    send(54'd100, 54'd200, 4'd9, 108'd20000);
    send(54'd123456789, 54'd1000, 4'd10, 108'd123456789000);
    send(54'd65535, 54'd65537, 4'd11, 108'd4294967295);
    fork
      send(54'd12, 54'd12, 4'd12, 108'd144);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    rdy_pat = 12'b1011_0011_1010;
    fork
      for (int k = 0; k < 6; k++) begin
        a = A_W'(k + 2);
        b = B_W'(k + 1000);
        send(a, b, TAG_W'(k), P_W'(a) * P_W'(b));
      end
      for (int k = 0; k < 12; k++) begin
        out_ready = rdy_pat[k];
        @(posedge clk);
        #1;
      end
    join
    out_ready = 1'b1;
    drain();
    lat_chk = 1'b1;

    // Reset with two beats in flight flushes both.
    send(54'd11, 54'd13, 4'd14, 108'd143);
    send(54'd17, 54'd19, 4'd15, 108'd323);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("flush_valid", out_valid, 0);
    repeat (3) @(negedge clk);
    check("flush_none", out_valid, 0);
    @(posedge clk);
    #1;
    send(54'd7, 54'd9, 4'd6, 108'd63);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_tiled_pipe.md
Name: mul_tiled_pipe

Overview:
Parametrised, pipelined unsigned multiplier. It splits A into TA-bit tiles and B into TB-bit tiles, and forms every tile product in a DSP-sized multiply. It then sums the shifted partial products into the full A_W+B_W-bit product. It has valid/ready handshakes on both sides, a passthrough tag, and replaces fixed-geometry blocks that exported only raw partial products.

Parameters:
A_W, 54, operand A width
B_W, 54, operand B width
TA, 27, A tile width (DSP A-port)
TB, 18, B tile width (DSP B-port)
TAG_W, 4, sideband tag width (min 1)
Derived: NA = ceil(A_W/TA), NB = ceil(B_W/TB), P_W = A_W+B_W

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
in_a  in  A_W  operand A, unsigned
in_b  in  B_W  operand B, unsigned
in_tag  in  TAG_W  sideband, carried with the operands
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
out_p  out  P_W  product in_a*in_b
out_tag  out  TAG_W  tag of the product

Behaviour:
- Reset is synchronous and active-high: rst sampled high on a clk edge clears all stage valid bits.
- After reset: out_valid=0, out_p=0, out_tag=0, in_ready=1.
- Pipeline has 3 stages:
  - S1 registers the operands, zero-extended to NA*TA and NB*TB bits.
  - S2 registers NA*NB tile products pp[i][j] = a_tile[i]*b_tile[j], each TA+TB bits.
  - S3 registers the sum of pp[i][j] << (i*TA + j*TB), truncated to P_W bits, together with the tag and valid.
- Latency: an accepted beat appears on out_* exactly 3 cycles after acceptance when no stall occurs.
- Handshake:
  - A beat is accepted when in_valid & in_ready.
  - A product transfers when out_valid & out_ready.
  - stall = out_valid & ~out_ready. While stalled, all stages hold and in_ready=0.
  - in_ready = ~stall. This is combinational from out_ready; no combinational path exists from in_valid.
  - Bubbles do not collapse; throughput is 1 beat/cycle with out_ready held high.
- Stage valid bits advance only when ~stall. A stage with valid=0 may load data; the data is don't-care, but out_p must hold its last value while out_valid=0.
- out_p, out_tag and out_valid must stay stable while stalled.
- rst mid-operation flushes all in-flight beats with no output. The first beat accepted after rst deasserts emerges 3 cycles later.
- A transfer at S3 and a new acceptance in the same cycle are legal and lose no beat.
- Widths that are not tile multiples are zero-padded; the result is still exact.
- Arithmetic is exact unsigned; there is no overflow, since P_W bits always hold the product.

Optional Feature:
Macro MUL_PP_OUT_EN.
- Defined: adds output pp_flat, width NA*NB*(TA+TB). It carries the raw S2 tile products delayed one cycle to align with out_p, with pp[i][j] at slice index j*NA+i. It is valid when out_valid, held during stall, and reset to 0. This is for debug and for legacy partial-product consumers.
- Undefined: no pp_flat port; S2 products are not retained past S3.

Test Plan:
- Reset then in_a=3, in_b=5, tag=1, out_ready=1 -> out_valid exactly 3 cycles after acceptance, out_p=15, out_tag=1.
- in_a=2^54-1, in_b=2^54-1 -> out_p=0xFFFFFFFFFFFFF80000000000001.
- Tile boundaries: a=2^27, b=2^18 -> out_p=2^45; a=2^53, b=2^53 -> out_p=2^106.
- 8 back-to-back random beats, out_ready=1 -> 8 products on 8 consecutive cycles, in order, tags matching, checked against a reference model.
- Random backpressure: out_ready low for 4 cycles with the pipe full -> in_ready=0 throughout, out_p/out_tag held, no beat lost or duplicated.
- Pulse rst with 2 beats in flight -> neither beat emerges; out_valid=0 next cycle; a post-reset 7*9 gives out_p=63 at latency 3.
